// File: rtl/ctrl_pkg.sv
// Shared types for ctrl_sequencer: opcode map, load FSM states, flag bit positions.
package ctrl_pkg;
  localparam int OPW_P = 4;
  localparam int CNT_W = 3;

  typedef enum logic [OPW_P-1:0] {
    OP_LOAD   = 4'b0000,
    OP_STORE  = 4'b0001,
    OP_XOR    = 4'b0010,
    OP_MOVIN  = 4'b0101,
    OP_MOVOUT = 4'b0110,
    OP_JLT    = 4'b1000,
    OP_JEQ    = 4'b1001,
    OP_JGT    = 4'b1010,
    OP_CMP    = 4'b1011
  } opcode_e;

  typedef enum logic {
    S_IDLE      = 1'b0,
    S_LOAD_WAIT = 1'b1
  } state_e;

  localparam int LT = 2;
  localparam int EQ = 1;
  localparam int GT = 0;
endpackage

// File: rtl/cmp_flags.sv
// Registered {lt,eq,gt} comparator with a sticky valid bit.
// Define CTRL_SIGNED_CMP_EN for two's-complement ordering; unsigned otherwise.
module cmp_flags
  import ctrl_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [2:0]    flags,
  output logic          flags_valid
);
  logic       lt, eq, gt;
  logic [2:0] flags_q;
  logic       valid_q;

`ifdef CTRL_SIGNED_CMP_EN
  logic signed [DW-1:0] a_s, b_s;
  assign a_s = $signed(a);
  assign b_s = $signed(b);
  assign lt  = (a_s < b_s);
  assign gt  = (a_s > b_s);
`else
  assign lt  = (a < b);
  assign gt  = (a > b);
`endif
  assign eq  = (a == b);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= '0;
      valid_q <= 1'b0;
    end else if (en) begin
      flags_q[LT] <= lt;
      flags_q[EQ] <= eq;
      flags_q[GT] <= gt;
      valid_q     <= 1'b1;
    end
  end

  assign flags       = flags_q;
  assign flags_valid = valid_q;
endmodule

// File: rtl/ctrl_sequencer.sv
// Instruction decoder with multi-cycle load FSM, fetch stall and compare-flag tracking.
// CTRL_SIGNED_CMP_EN selects signed compare in the cmp_flags instance.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int OPW     = 4,
  parameter int FW      = 5,
  parameter int RIDX    = 4,
  parameter int DW      = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [OPW+FW-1:0] instr,
  input  logic [DW-1:0]     cmp_a,
  input  logic [DW-1:0]     cmp_b,
  output logic              stall,
  output logic [RIDX-1:0]   rd_a,
  output logic [RIDX-1:0]   rd_b,
  output logic [FW-1:0]     addr,
  output logic [OPW-1:0]    alu_op,
  output logic              branch,
  output logic              mem_write,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic              acc_write,
  output logic              alu_src,
  output logic              is_mov_in,
  output logic              is_mov_out,
  output logic [2:0]        flags,
  output logic              flags_valid
);
  localparam logic [OPW-1:0]   C_LOAD   = OPW'(OP_LOAD);
  localparam logic [OPW-1:0]   C_STORE  = OPW'(OP_STORE);
  localparam logic [OPW-1:0]   C_XOR    = OPW'(OP_XOR);
  localparam logic [OPW-1:0]   C_MOVIN  = OPW'(OP_MOVIN);
  localparam logic [OPW-1:0]   C_MOVOUT = OPW'(OP_MOVOUT);
  localparam logic [OPW-1:0]   C_JLT    = OPW'(OP_JLT);
  localparam logic [OPW-1:0]   C_JEQ    = OPW'(OP_JEQ);
  localparam logic [OPW-1:0]   C_JGT    = OPW'(OP_JGT);
  localparam logic [OPW-1:0]   C_CMP    = OPW'(OP_CMP);
  localparam logic [CNT_W-1:0] LAT_M1   = CNT_W'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);

  logic [OPW-1:0]   opcode;
  logic [FW-1:0]    field;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cmp_en;

  assign opcode  = instr[OPW+FW-1:FW];
  assign field   = instr[FW-1:0];
  assign alu_src = 1'b0;

  // Reset forces every decoded output low; flags are cleared by their own async reset.
  always_comb begin
    stall      = 1'b0;
    rd_a       = '0;
    rd_b       = '0;
    addr       = '0;
    alu_op     = '0;
    branch     = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    acc_write  = 1'b0;
    is_mov_in  = 1'b0;
    is_mov_out = 1'b0;
    cmp_en     = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    if (reset) begin
      state_d = S_IDLE;
    end else if (state_q == S_LOAD_WAIT) begin
      mem_to_reg = 1'b1;
      acc_write  = 1'b1;
      if (cnt_q != '0) begin
        stall = 1'b1;
        cnt_d = cnt_q - 1'b1;
      end else begin
        reg_write = 1'b1;
        state_d   = S_IDLE;
      end
    end else if (instr_valid) begin
      alu_op    = opcode;
      addr      = field;
      rd_a      = RIDX'(opcode);
      reg_write = 1'b1;
      acc_write = 1'b1;
      case (opcode)
        C_LOAD: begin
          mem_to_reg = 1'b1;
          if (MEM_LAT != 0) begin
            reg_write = 1'b0;
            stall     = 1'b1;
            cnt_d     = LAT_M1;
            state_d   = S_LOAD_WAIT;
          end
        end
        C_STORE: begin
          mem_write = 1'b1;
          reg_write = 1'b0;
        end
        C_XOR: begin
          if (field[FW-1]) begin
            rd_a = RIDX'(2);
            rd_b = RIDX'(4);
          end else begin
            rd_a = RIDX'(1);
            rd_b = RIDX'(3);
          end
        end
        C_MOVIN: begin
          rd_a      = RIDX'(field[FW-1:1]);
          is_mov_in = 1'b1;
        end
        C_MOVOUT: begin
          rd_a       = RIDX'(field[FW-1:1]);
          is_mov_out = 1'b1;
          acc_write  = 1'b0;
        end
        C_CMP: begin
          rd_a      = RIDX'(field[FW-1:FW/2]);
          rd_b      = RIDX'(field[FW/2-1:0]);
          reg_write = 1'b0;
          acc_write = 1'b0;
          cmp_en    = 1'b1;
        end
        C_JLT: begin
          reg_write = 1'b0;
          acc_write = 1'b0;
          branch    = flags[LT] & flags_valid;
        end
        C_JEQ: begin
          reg_write = 1'b0;
          acc_write = 1'b0;
          branch    = flags[EQ] & flags_valid;
        end
        C_JGT: begin
          reg_write = 1'b0;
          acc_write = 1'b0;
          branch    = flags[GT] & flags_valid;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  cmp_flags #(.DW(DW)) u_cmp_flags (
    .clk         (clk),
    .reset       (reset),
    .en          (cmp_en),
    .a           (cmp_a),
    .b           (cmp_b),
    .flags       (flags),
    .flags_valid (flags_valid)
  );
endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer (MEM_LAT=2): directed cases plus randomized traffic against a behavioural model.
module tb_ctrl_sequencer;
  localparam int OPW = 4, FW = 5, RIDX = 4, DW = 8, LAT = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              instr_valid;
  logic [OPW+FW-1:0] instr;
  logic [DW-1:0]     cmp_a, cmp_b;
  logic              stall, branch, mem_write, mem_to_reg, reg_write, acc_write;
  logic              alu_src, is_mov_in, is_mov_out, flags_valid;
  logic [RIDX-1:0]   rd_a, rd_b;
  logic [FW-1:0]     addr;
  logic [OPW-1:0]    alu_op;
  logic [2:0]        flags;
  logic [29:0]       outv;

  int npass = 0;
  int ntot  = 0;

  // Model state: lk = cycles already spent in a load (0 = no load in flight).
  int         lk  = 0;
  logic [2:0] mf  = 3'b000;
  logic       mfv = 1'b0;

  always #5 clk = ~clk;

  ctrl_sequencer #(.OPW(OPW), .FW(FW), .RIDX(RIDX), .DW(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .stall(stall), .rd_a(rd_a), .rd_b(rd_b),
    .addr(addr), .alu_op(alu_op), .branch(branch), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .acc_write(acc_write),
    .alu_src(alu_src), .is_mov_in(is_mov_in), .is_mov_out(is_mov_out),
    .flags(flags), .flags_valid(flags_valid)
  );

  assign outv = {stall, rd_a, rd_b, addr, alu_op, branch, mem_write, mem_to_reg,
                 reg_write, acc_write, alu_src, is_mov_in, is_mov_out, flags, flags_valid};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [2:0] cmp_model(input logic [7:0] a, input logic [7:0] b);
    logic lt, gt;
`ifdef CTRL_SIGNED_CMP_EN
    lt = $signed(a) < $signed(b);
    gt = $signed(a) > $signed(b);
`else
    lt = a < b;
    gt = a > b;
`endif
    return {lt, a == b, gt};
  endfunction

  function automatic logic [29:0] expect_out(input logic v, input logic [8:0] ins, input int k,
                                             input logic [2:0] f, input logic fvl);
    logic       st, br, mw, m2r, rw, aw, mi, mo;
    logic [3:0] op, ra, rb, alu;
    logic [4:0] fld, ad;
    op = ins[8:5];
    fld = ins[4:0];
    st = 0; br = 0; mw = 0; m2r = 0; rw = 0; aw = 0; mi = 0; mo = 0;
    ra = 0; rb = 0; alu = 0; ad = 0;
    if (k > 0) begin
      m2r = 1; aw = 1;
      st = (k < LAT);
      rw = (k == LAT);
    end else if (v) begin
      alu = op; ad = fld; ra = op; rw = 1; aw = 1;
      case (op)
        4'd0:  begin m2r = 1; st = (LAT > 0); rw = (LAT == 0); end
        4'd1:  begin mw = 1; rw = 0; end
        4'd2:  begin ra = fld[4] ? 4'd2 : 4'd1; rb = fld[4] ? 4'd4 : 4'd3; end
        4'd5:  begin ra = fld[4:1]; mi = 1; end
        4'd6:  begin ra = fld[4:1]; mo = 1; aw = 0; end
        4'd8:  begin rw = 0; aw = 0; br = f[2] & fvl; end
        4'd9:  begin rw = 0; aw = 0; br = f[1] & fvl; end
        4'd10: begin rw = 0; aw = 0; br = f[0] & fvl; end
        4'd11: begin ra = {1'b0, fld[4:2]}; rb = {2'b00, fld[1:0]}; rw = 0; aw = 0; end
        default: ;
      endcase
    end
    return {st, ra, rb, ad, alu, br, mw, m2r, rw, aw, 1'b0, mi, mo, f, fvl};
  endfunction

  always @(negedge clk) begin
    logic [29:0] e;
    if (reset) e = '0;
    else e = expect_out(instr_valid, instr, lk, mf, mfv);
    chk("cycle_outputs", 32'(outv), 32'(e));
    if (reset) begin
      lk = 0; mf = 3'b000; mfv = 1'b0;
    end else if (lk > 0) begin
      lk = (lk < LAT) ? lk + 1 : 0;
    end else if (instr_valid) begin
      if (instr[8:5] == 4'd0 && LAT > 0) lk = 1;
      if (instr[8:5] == 4'd11) begin
        mf = cmp_model(cmp_a, cmp_b);
        mfv = 1'b1;
      end
    end
  end

  task automatic setin(input logic v, input logic [8:0] ins, input logic [7:0] a, input logic [7:0] b);
    instr_valid = v; instr = ins; cmp_a = a; cmp_b = b;
  endtask

  task automatic next_cycle;
    @(posedge clk); #1;
  endtask

  initial begin
    logic hold;
    logic [3:0] op;
    logic [7:0] a, b;
    reset = 1'b1;
    setin(1'b1, 9'b0010_10000, 8'd0, 8'd0);
    #2;
    chk("reset_all_zero", 32'(outv), 32'd0);

    next_cycle(); reset = 1'b0;
    setin(1'b1, 9'b1001_00011, 8'd0, 8'd0);
    @(negedge clk);
    chk("jeq_after_reset_branch", 32'(branch), 32'd0);
    chk("jeq_after_reset_fv", 32'(flags_valid), 32'd0);
    chk("jeq_addr", 32'(addr), 32'd3);

    next_cycle(); setin(1'b1, 9'b1011_00110, 8'd5, 8'd9);
    @(negedge clk);
    chk("cmp_rd_a", 32'(rd_a), 32'd1);
    chk("cmp_rd_b", 32'(rd_b), 32'd2);
    chk("cmp_reg_write", 32'(reg_write), 32'd0);

    next_cycle(); setin(1'b1, 9'b1000_00111, 8'd0, 8'd0);
    @(negedge clk);
    chk("jlt_flags", 32'(flags), 32'b100);
    chk("jlt_branch", 32'(branch), 32'd1);
    chk("jlt_addr", 32'(addr), 32'd7);

    next_cycle(); setin(1'b1, 9'b1010_00000, 8'd0, 8'd0);
    @(negedge clk);
    chk("jgt_branch", 32'(branch), 32'd0);

    next_cycle(); setin(1'b1, 9'b0000_00000, 8'd0, 8'd0);
    @(negedge clk);
    chk("load_c0", 32'({stall, reg_write, mem_to_reg}), 32'b101);
    next_cycle();
    @(negedge clk);
    chk("load_c1", 32'({stall, reg_write, mem_to_reg}), 32'b101);
    next_cycle();
    @(negedge clk);
    chk("load_c2", 32'({stall, reg_write, mem_to_reg}), 32'b011);

    next_cycle(); setin(1'b1, 9'b0101_01100, 8'd0, 8'd0);
    @(negedge clk);
    chk("movin", 32'({rd_a, is_mov_in, acc_write}), 32'({4'd6, 1'b1, 1'b1}));

    next_cycle(); setin(1'b1, 9'b0001_10101, 8'd0, 8'd0);
    @(negedge clk);
    chk("store", 32'({mem_write, reg_write}), 32'b10);

    next_cycle(); setin(1'b1, 9'b1011_00000, 8'h80, 8'h01);
    next_cycle(); setin(1'b0, 9'd0, 8'd0, 8'd0);
    @(negedge clk);
`ifdef CTRL_SIGNED_CMP_EN
    chk("cmp_sign_flags", 32'(flags), 32'b100);
`else
    chk("cmp_sign_flags", 32'(flags), 32'b001);
`endif

    next_cycle(); setin(1'b1, 9'b0000_00000, 8'd0, 8'd0);
    next_cycle(); #2;
    reset = 1'b1;
    #1;
    chk("reset_mid_load", 32'(outv), 32'd0);
    next_cycle(); reset = 1'b0; setin(1'b0, 9'd0, 8'd0, 8'd0);
    @(negedge clk);
    chk("after_abort_idle", 32'({stall, reg_write, mem_to_reg, flags_valid}), 32'd0);
    next_cycle(); setin(1'b1, 9'b0000_00000, 8'd0, 8'd0);
    @(negedge clk);
    chk("after_abort_new_load", 32'({stall, reg_write}), 32'b10);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      hold = stall;
      next_cycle();
      if (!hold) begin
        case ($urandom_range(0, 5))
          0: op = 4'd0;
          1: op = 4'd11;
          2: op = 4'd8 + 4'($urandom_range(0, 2));
          default: op = 4'($urandom_range(0, 15));
        endcase
        case ($urandom_range(0, 3))
          0: begin a = 8'($urandom_range(0, 255)); b = a; end
          1: begin a = 8'h80; b = 8'h7f; end
          default: begin a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255)); end
        endcase
        setin(($urandom_range(0, 9) != 0), {op, 5'($urandom_range(0, 31))}, a, b);
      end
    end

    next_cycle();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Parametrised, sequenced successor to the single-cycle control decoder. It decodes each fetched instruction into datapath controls (register file, accumulator, ALU, data memory, branch), and holds the compare-flag register. It adds a multi-cycle load state machine with a stall handshake toward fetch, and flag validity tracking so jumps never act on stale or reset flags. It sits between instruction fetch/ROM and the datapath, with the register-file read ports feeding its compare inputs.

## Interface
- OPW, 4, opcode width (instr upper field)
- FW, 5, operand field width (instr lower field; also jump LUT address width)
- RIDX, 4, register index width
- DW, 8, compare operand width
- MEM_LAT, 1, extra data-memory read cycles for load (0..7)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- instr_valid  in  1  instr holds a new instruction
- instr  in  OPW+FW  opcode = instr[OPW+FW-1:FW], field = instr[FW-1:0]
- cmp_a, cmp_b  in  DW  register-file read data for compare
- stall  out  1  fetch must hold instr and PC
- rd_a, rd_b  out  RIDX  register read/write indices
- addr  out  FW  jump LUT index = field
- alu_op  out  OPW  equals opcode
- branch, mem_write, mem_to_reg, reg_write, acc_write, alu_src, is_mov_in, is_mov_out  out  1 each  datapath controls
- flags  out  3  {lt, eq, gt} registered compare result
- flags_valid  out  1  a compare has completed since reset

## Operation
- Opcode map: 0000 load, 0001 store, 0010 xor, 0101 mov-in (reg→acc), 0110 mov-out (acc→reg), 1000 JLT, 1001 JEQ, 1010 JGT, 1011 CMP; all others are plain ALU ops.
- Defaults (valid, non-special opcode): reg_write=1, acc_write=1, rd_a=opcode zero-extended/truncated to RIDX, rd_b=0, all other controls 0.
- instr_valid=0: every control output 0, rd_a=rd_b=0, addr=0, no state change.
- store: mem_write=1, reg_write=0.
- xor: field MSB 0 → rd_a=1, rd_b=3; 1 → rd_a=2, rd_b=4.
- mov-in: rd_a=field[FW-1:1], is_mov_in=1, acc_write=1. mov-out: same rd_a, is_mov_out=1, acc_write=0.
- CMP: rd_a=field[FW-1:FW/2], rd_b=field[FW/2-1:0], zero-extended; reg_write=0, acc_write=0. Flags capture at end of the cycle; exactly one flag set. flags_valid sets.
- JLT/JEQ/JGT: reg_write=0, acc_write=0; branch = selected flag AND flags_valid. Uses the registered flags only.
- Load FSM states IDLE, LOAD_WAIT:
  - IDLE + valid load, MEM_LAT=0: mem_to_reg=1, reg_write=1, single cycle.
  - IDLE + valid load, MEM_LAT>0: mem_to_reg=1, reg_write=0, stall=1; counter←MEM_LAT-1; go to LOAD_WAIT.
  - LOAD_WAIT: mem_to_reg=1. Counter≠0: stall=1, reg_write=0, decrement. Counter=0: stall=0, reg_write=1, return to IDLE.
  - instr is ignored (held by fetch) in LOAD_WAIT; no flag update occurs there.

## Timing
- Decode is combinational from instr and state; zero latency, except for load.
- Load occupies MEM_LAT+1 cycles; the stall high time is exactly MEM_LAT cycles.
- CMP in cycle N affects a jump in cycle N+1 onward. CMP followed immediately by a jump is legal and uses the new flags.
- Reset (asynchronous): state=IDLE, counter=0, flags=000, flags_valid=0, stall=0. While reset is high, every output is 0.
- Reset during LOAD_WAIT aborts the load; reg_write never asserts for it.
- Back-to-back loads: the second load's issue cycle follows the first load's completion cycle. No bubble is required.

## Configuration
- CTRL_SIGNED_CMP_EN defined: CMP treats cmp_a/cmp_b as two's-complement.
- Undefined: unsigned compare. Equality is unaffected.

## Structure
- Package ctrl_pkg: opcode enum (width OPW), FSM state enum, flag index constants LT/EQ/GT.
- Sub-module cmp_flags: registered comparator holding flags and flags_valid, signedness chosen by the macro. Decode and FSM live in ctrl_sequencer.

## Test plan
- After reset, JEQ (instr=1001_00011) → branch=0, flags_valid=0, addr=3.
- CMP 1011_01_10 with cmp_a=5, cmp_b=9, then JLT 1000_00111 → flags=100, branch=1, addr=7; JGT next → branch=0.
- MEM_LAT=2, load 0000_00000 → stall=1,1,0; reg_write=0,0,1; mem_to_reg=1 on all three cycles.
- Reset asserted in the second load cycle → outputs 0 immediately, state IDLE, no reg_write pulse.
- cmp_a=0x80, cmp_b=0x01 → gt=1 without CTRL_SIGNED_CMP_EN, lt=1 with it.
- mov-in 0101_01100 → rd_a=6, is_mov_in=1, acc_write=1. store 0001_xxxxx → mem_write=1, reg_write=0.
